// File: rtl/video_pkg.sv
// Shared types, channel tags and elaboration helpers for the video capture path.
package video_pkg;

    localparam int unsigned PIX_W_DEF = 16;

    typedef logic [PIX_W_DEF-1:0] rgb565_t;

    localparam logic [3:0] TAG_CH0 = 4'd1;
    localparam logic [3:0] TAG_CH1 = 4'd2;
    localparam logic [3:0] TAG_CH2 = 4'd3;
    localparam logic [3:0] TAG_CH3 = 4'd4;

    // Ceiling log2, usable in parameter and port declarations.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with wrap-bit pointers, flush and a registered read port.
module sync_word_fifo
    import video_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [clog2(DEPTH):0]  level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             do_push, do_pop;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign level    = wr_ptr_q - rd_ptr_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

    // Flush wins over push and pop issued in the same cycle.
    always_comb begin
        do_push    = push & ~full & ~flush;
        do_pop     = pop & ~empty & ~flush;
        wr_ptr_d   = flush ? '0 : wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + (AW+1)'(do_pop);
        rd_data_d  = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : rd_data_q;
        rd_valid_d = do_pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/video_scaler_packer.sv
// Crops and decimates an RGB565 stream, packs pixels into DDR words and requests bursts.
// Optional VIDEO_SCALER_FRAME_FLUSH_EN: pad/push the last partial word and drain the tail.
module video_scaler_packer
    import video_pkg::*;
#(
    parameter int unsigned DQ_WIDTH   = 32,
    parameter int unsigned PIX_W      = PIX_W_DEF,
    parameter int unsigned FIFO_DEPTH = 256,
    parameter int unsigned BURST_LEN  = 16,
    parameter logic [3:0]  IMAGE_TAG  = TAG_CH0,
    parameter int unsigned LINE_W     = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          de_in,
    input  logic                          vs_in,
    input  logic [PIX_W-1:0]              rgb565_in,
    input  logic [3:0]                    h_keep,
    input  logic [3:0]                    h_period,
    input  logic [3:0]                    v_keep,
    input  logic [3:0]                    v_period,
    input  logic [LINE_W-1:0]             row_start,
    input  logic [LINE_W-1:0]             row_end,
    input  logic                          rd_en,
    output logic [DQ_WIDTH*8-1:0]         rd_data,
    output logic                          rd_valid,
    output logic [clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                          burst_emergency,
    output logic                          overflow,
    output logic                          data_out_ready,
    output logic [3:0]                    trans_id
);

    localparam int unsigned WORD_W = DQ_WIDTH * 8;
    localparam int unsigned PPW    = WORD_W / PIX_W;
    localparam int unsigned SW     = clog2(PPW);
    localparam int unsigned LVL_W  = clog2(FIFO_DEPTH) + 1;

    logic              vs_q, vs_d, de_q, de_d;
    logic [3:0]        h_keep_q, h_keep_d, h_per_q, h_per_d;
    logic [3:0]        v_keep_q, v_keep_d, v_per_q, v_per_d;
    logic [LINE_W-1:0] row_start_q, row_start_d, row_end_q, row_end_d;
    logic [LINE_W-1:0] row_q, row_d;
    logic [3:0]        v_phase_q, v_phase_d, h_phase_q, h_phase_d;
    logic              pix_vld_q, pix_vld_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [WORD_W-1:0] word_q, word_d, out_word_q, out_word_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic              push_q, push_d;
    logic              overflow_q, overflow_d;
    logic              ready_q, ready_d;
    logic [3:0]        trans_id_q, trans_id_d;
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
    logic              tail_q, tail_d, drain_q, drain_d;
`endif

    logic              frame_start, de_rise, de_fall, in_win, row_kept;
    logic [3:0]        h_cur;
    logic              fifo_full, fifo_empty;
    logic [LVL_W-1:0]  level;

    always_comb begin
        frame_start = vs_in & ~vs_q;
        de_rise     = de_in & ~de_q;
        de_fall     = ~de_in & de_q;
        in_win      = (row_q >= row_start_q) && (row_q <= row_end_q);
        row_kept    = in_win && (v_phase_q < v_keep_q);
        h_cur       = de_rise ? 4'd0 : h_phase_q;

        vs_d        = vs_in;
        de_d        = de_in;
        h_keep_d    = h_keep_q;
        h_per_d     = h_per_q;
        v_keep_d    = v_keep_q;
        v_per_d     = v_per_q;
        row_start_d = row_start_q;
        row_end_d   = row_end_q;
        row_d       = de_fall ? row_q + LINE_W'(1) : row_q;
        v_phase_d   = v_phase_q;
        h_phase_d   = h_phase_q;
        pix_vld_d   = de_in && row_kept && (h_cur < h_keep_q);
        pix_d       = pix_vld_d ? rgb565_in : pix_q;
        word_d      = word_q;
        out_word_d  = out_word_q;
        slot_d      = slot_q;
        push_d      = 1'b0;
        overflow_d  = overflow_q | (push_q & fifo_full);
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
        tail_d      = de_fall && in_win && (row_q == row_end_q);
        drain_d     = tail_q | (drain_q & ~(fifo_empty & ~push_q));
        ready_d     = ~fifo_empty & ((level >= LVL_W'(BURST_LEN)) | drain_q);
`else
        ready_d     = ~fifo_empty & (level >= LVL_W'(BURST_LEN));
`endif
        trans_id_d  = ready_d ? IMAGE_TAG : 4'd0;

        // Phase counters wrap at (period - 1); period is stored already clamped to >= 1.
        if (de_fall && in_win) begin
            v_phase_d = (v_phase_q >= v_per_q - 4'd1) ? 4'd0 : v_phase_q + 4'd1;
        end
        if (de_in) begin
            h_phase_d = (h_cur >= h_per_q - 4'd1) ? 4'd0 : h_cur + 4'd1;
        end

        // Packer: fill ascending slots, hand a completed word to the FIFO next cycle.
        if (pix_vld_q) begin
            if (slot_q == SW'(PPW - 1)) begin
                out_word_d = word_q;
                out_word_d[int'(slot_q)*PIX_W +: PIX_W] = pix_q;
                word_d = '0;
                slot_d = '0;
                push_d = 1'b1;
            end else begin
                word_d[int'(slot_q)*PIX_W +: PIX_W] = pix_q;
                slot_d = slot_q + SW'(1);
            end
        end
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
        else if (tail_q && (slot_q != '0)) begin
            out_word_d = word_q;
            word_d     = '0;
            slot_d     = '0;
            push_d     = 1'b1;
        end
`endif

        if (frame_start) begin
            h_keep_d    = h_keep;
            h_per_d     = (h_period == 4'd0) ? 4'd1 : h_period;
            v_keep_d    = v_keep;
            v_per_d     = (v_period == 4'd0) ? 4'd1 : v_period;
            row_start_d = row_start;
            row_end_d   = row_end;
            row_d       = '0;
            v_phase_d   = '0;
            h_phase_d   = '0;
            pix_vld_d   = 1'b0;
            word_d      = '0;
            slot_d      = '0;
            push_d      = 1'b0;
            overflow_d  = 1'b0;
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
            tail_d      = 1'b0;
            drain_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            h_keep_q    <= '0;
            h_per_q     <= '0;
            v_keep_q    <= '0;
            v_per_q     <= '0;
            row_start_q <= '0;
            row_end_q   <= '0;
            row_q       <= '0;
            v_phase_q   <= '0;
            h_phase_q   <= '0;
            pix_vld_q   <= 1'b0;
            pix_q       <= '0;
            word_q      <= '0;
            out_word_q  <= '0;
            slot_q      <= '0;
            push_q      <= 1'b0;
            overflow_q  <= 1'b0;
            ready_q     <= 1'b0;
            trans_id_q  <= '0;
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
            tail_q      <= 1'b0;
            drain_q     <= 1'b0;
`endif
        end else begin
            vs_q        <= vs_d;
            de_q        <= de_d;
            h_keep_q    <= h_keep_d;
            h_per_q     <= h_per_d;
            v_keep_q    <= v_keep_d;
            v_per_q     <= v_per_d;
            row_start_q <= row_start_d;
            row_end_q   <= row_end_d;
            row_q       <= row_d;
            v_phase_q   <= v_phase_d;
            h_phase_q   <= h_phase_d;
            pix_vld_q   <= pix_vld_d;
            pix_q       <= pix_d;
            word_q      <= word_d;
            out_word_q  <= out_word_d;
            slot_q      <= slot_d;
            push_q      <= push_d;
            overflow_q  <= overflow_d;
            ready_q     <= ready_d;
            trans_id_q  <= trans_id_d;
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
            tail_q      <= tail_d;
            drain_q     <= drain_d;
`endif
        end
    end

    sync_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (frame_start),
        .push     (push_q),
        .wr_data  (out_word_q),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign fifo_level      = level;
    assign burst_emergency = fifo_full;
    assign overflow        = overflow_q;
    assign data_out_ready  = ready_q;
    assign trans_id        = trans_id_q;

endmodule

// File: tb/tb_video_scaler_packer.sv
// Directed bench for video_scaler_packer: packing, decimation, FIFO limits, request timing, reset.
module tb_video_scaler_packer;
    import video_pkg::*;

    localparam int unsigned W = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          de_in = 1'b0, vs_in = 1'b0, rd_en = 1'b0;
    logic [15:0]   rgb565_in = '0;
    logic [3:0]    h_keep = '0, h_period = '0, v_keep = '0, v_period = '0;
    logic [10:0]   row_start = '0, row_end = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid, burst_emergency, overflow, data_out_ready;
    logic [8:0]    fifo_level;
    logic [3:0]    trans_id;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0]  w [16];

    video_scaler_packer dut (
        .clk(clk), .rst(rst), .de_in(de_in), .vs_in(vs_in), .rgb565_in(rgb565_in),
        .h_keep(h_keep), .h_period(h_period), .v_keep(v_keep), .v_period(v_period),
        .row_start(row_start), .row_end(row_end), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .fifo_level(fifo_level),
        .burst_emergency(burst_emergency), .overflow(overflow),
        .data_out_ready(data_out_ready), .trans_id(trans_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_frame(input logic [3:0] hk, input logic [3:0] hp, input logic [3:0] vk,
                             input logic [3:0] vp, input logic [10:0] rs, input logic [10:0] re);
        @(negedge clk);
        h_keep = hk; h_period = hp; v_keep = vk; v_period = vp;
        row_start = rs; row_end = re; vs_in = 1'b1;
        @(negedge clk);
        vs_in = 1'b0;
        idle(2);
    endtask

    task automatic send_row(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            de_in = 1'b1;
            rgb565_in = 16'(base + i);
        end
        @(negedge clk);
        de_in = 1'b0;
        rgb565_in = '0;
        idle(6);
    endtask

    task automatic pop(output logic [W-1:0] word);
        @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("rd_valid", W'(rd_valid), W'(1));
        word = rd_data;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_level", W'(fifo_level), W'(0));
        check("rst_ready", W'(data_out_ready), W'(0));
        check("rst_tid", W'(trans_id), W'(0));
        check("rst_ovf", W'(overflow), W'(0));
        check("rst_emerg", W'(burst_emergency), W'(0));
        check("rst_rdv", W'(rd_valid), W'(0));
        check("rst_rdata", rd_data, W'(0));
        rst = 1'b1;
        idle(2);

        // Full-rate 32-pixel row -> two words
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd0, 11'd0);
        send_row(32, 0);
        check("full_level", W'(fifo_level), W'(2));
        pop(w[0]);
        pop(w[1]);
        check("full_w0_s0", W'(w[0][15:0]), W'(0));
        check("full_w0_s15", W'(w[0][255:240]), W'(15));
        check("full_w1_s0", W'(w[1][15:0]), W'(16));
        check("full_w1_s15", W'(w[1][255:240]), W'(31));
        check("full_drained", W'(fifo_level), W'(0));

        // h 3/4 over two rows, config changes mid-frame must be ignored
        new_frame(4'd3, 4'd4, 4'd1, 4'd1, 11'd0, 11'd1);
        h_keep = 4'd1; h_period = 4'd1; v_keep = 4'd0; row_start = 11'd5; row_end = 11'd5;
        send_row(32, 0);
        send_row(32, 0);
        check("h34_level", W'(fifo_level), W'(3));
        pop(w[0]);
        pop(w[1]);
        pop(w[2]);
        check("h34_w0_s3", W'(w[0][63:48]), W'(4));
        check("h34_w0_s15", W'(w[0][255:240]), W'(20));
        check("h34_w1_s7", W'(w[1][127:112]), W'(30));
        check("h34_w1_s8", W'(w[1][143:128]), W'(0));
        check("h34_w1_s15", W'(w[1][255:240]), W'(9));
        check("h34_w2_s15", W'(w[2][255:240]), W'(30));

        // v 1/2 with row window 1..4 over rows 0..5
        new_frame(4'd1, 4'd1, 4'd1, 4'd2, 11'd1, 11'd4);
        for (int r = 0; r < 6; r++) send_row(16, r << 8);
        check("v12_level", W'(fifo_level), W'(2));
        pop(w[0]);
        pop(w[1]);
        check("v12_w0_s0", W'(w[0][15:0]), W'(16'h0100));
        check("v12_w1_s0", W'(w[1][15:0]), W'(16'h0300));
        check("v12_w1_s15", W'(w[1][255:240]), W'(16'h030F));

        // keep = 0, empty window, period = 0 and keep >= period
        new_frame(4'd0, 4'd4, 4'd1, 4'd1, 11'd0, 11'd0);
        send_row(32, 0);
        check("hkeep0_level", W'(fifo_level), W'(0));
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd3, 11'd2);
        for (int r = 0; r < 5; r++) send_row(16, 0);
        check("emptywin_level", W'(fifo_level), W'(0));
        new_frame(4'd1, 4'd0, 4'd5, 4'd0, 11'd0, 11'd0);
        send_row(16, 16'h40);
        check("per0_level", W'(fifo_level), W'(1));
        pop(w[0]);
        check("per0_s0", W'(w[0][15:0]), W'(16'h40));
        check("per0_s15", W'(w[0][255:240]), W'(16'h4F));

        // 40 pixels: partial word discarded, or padded and pushed when the tail flush is built in
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd0, 11'd0);
        send_row(40, 0);
`ifdef VIDEO_SCALER_FRAME_FLUSH_EN
        check("tail_level", W'(fifo_level), W'(3));
        pop(w[0]);
        pop(w[1]);
        pop(w[2]);
        check("tail_w2_s0", W'(w[2][15:0]), W'(32));
        check("tail_w2_pad", W'(w[2][255:128]), W'(0));
`else
        check("tail_level", W'(fifo_level), W'(2));
`endif

        // Overflow: 260 words with no pops
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd0, 11'd7);
        for (int r = 0; r < 8; r++) send_row(520, 0);
        check("ovf_level", W'(fifo_level), W'(256));
        check("ovf_emerg", W'(burst_emergency), W'(1));
        check("ovf_flag", W'(overflow), W'(1));
        check("ovf_ready", W'(data_out_ready), W'(1));
        check("ovf_tid", W'(trans_id), W'(1));
        pop(w[0]);
        check("ovf_level_pop", W'(fifo_level), W'(255));
        check("ovf_sticky", W'(overflow), W'(1));
        check("ovf_emerg_pop", W'(burst_emergency), W'(0));
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd0, 11'd1);
        check("ovf_clear", W'(overflow), W'(0));
        check("flush_level", W'(fifo_level), W'(0));
        check("flush_ready", W'(data_out_ready), W'(0));

        // Request timing around the 15 -> 16 crossing, then one full burst
        send_row(240, 0);
        check("rq_level15", W'(fifo_level), W'(15));
        check("rq_ready15", W'(data_out_ready), W'(0));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            de_in = 1'b1;
            rgb565_in = 16'(i);
        end
        @(negedge clk);
        de_in = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fifo_level == 9'd16) break;
        end
        check("rq_reach16", W'(fifo_level), W'(16));
        check("rq_ready_same", W'(data_out_ready), W'(0));
        check("rq_tid_same", W'(trans_id), W'(0));
        @(negedge clk);
        check("rq_ready_next", W'(data_out_ready), W'(1));
        check("rq_tid_next", W'(trans_id), W'(1));
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("burst_valid", W'(rd_valid), W'(1));
            w[k] = rd_data;
            if (k == 15) rd_en = 1'b0;
        end
        check("burst_w0", W'(w[0][15:0]), W'(0));
        check("burst_w14", W'(w[14][15:0]), W'(224));
        check("burst_w15", W'(w[15][255:240]), W'(15));
        idle(2);
        check("burst_level0", W'(fifo_level), W'(0));
        check("burst_ready0", W'(data_out_ready), W'(0));
        check("burst_tid0", W'(trans_id), W'(0));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("empty_pop_valid", W'(rd_valid), W'(0));
        check("empty_pop_hold", rd_data, w[15]);

        // Asynchronous reset in the middle of a row
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd0, 11'd0);
        send_row(32, 100);
        pop(w[0]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            de_in = 1'b1;
            rgb565_in = 16'(i);
        end
        #2 rst = 1'b0;
        #1;
        check("mrst_level", W'(fifo_level), W'(0));
        check("mrst_rdata", rd_data, W'(0));
        check("mrst_rdv", W'(rd_valid), W'(0));
        check("mrst_ready", W'(data_out_ready), W'(0));
        check("mrst_tid", W'(trans_id), W'(0));
        check("mrst_ovf", W'(overflow), W'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            de_in = 1'b1;
            rgb565_in = 16'(i);
        end
        @(negedge clk);
        de_in = 1'b0;
        idle(6);
        check("mrst_no_frame", W'(fifo_level), W'(0));
        new_frame(4'd1, 4'd1, 4'd1, 4'd1, 11'd0, 11'd0);
        send_row(16, 16'h55);
        check("mrst_resume", W'(fifo_level), W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
